register_file: RTL and testbench
================================

Name: register_file

Overview:
- Operand register bank sitting directly upstream of the ALU.
- Holds four general-purpose registers (R1–R4) and four scratch registers (S1–S4).
- Applies a per-cycle register micro-operation (FunSel) to any selected subset of registers.
- Drives the ALU's A and B operand buses through two independent read selectors.
- Input I is normally ALUOut or a memory/IR mux output, which closes the datapath loop.

Parameters:
- WIDTH, 32, register and data-bus width in bits; must be at least 16.

Ports:
- Clock    input   1      rising-edge clock, the single clock of the block.
- Reset    input   1      synchronous, active-high; clears all eight registers.
- I        input   WIDTH  write data.
- FunSel   input   3      register micro-operation applied to all selected registers.
- RegSel   input   4      write enables; bit3=R1, bit2=R2, bit1=R3, bit0=R4; active-high.
- ScrSel   input   4      write enables; bit3=S1, bit2=S2, bit1=S3, bit0=S4; active-high.
- OutASel  input   3      A read select: 000–011 = R1–R4, 100–111 = S1–S4.
- OutBSel  input   3      B read select, same encoding as OutASel.
- OutA     output  WIDTH  selected register value; feeds ALU A.
- OutB     output  WIDTH  selected register value; feeds ALU B.

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high.
  - At a rising edge with Reset=1, all eight registers become 0.
  - Reset overrides FunSel, RegSel and ScrSel.
  - Consequently OutA = OutB = 0 from the cycle after reset.
  - Reset asserted mid-sequence discards that cycle's write; there is no partial update.
- Reads:
  - OutA and OutB are purely combinational muxes of current register contents.
  - No write-to-read bypass: a write at edge n is visible on OutA/OutB only after edge n.
  - A and B may select the same register.
- Writes: at each rising edge with Reset=0, every register whose enable bit is 1 takes the FunSel result computed from its own current value (Q) and I. Unselected registers hold.
- FunSel encoding:
  - 000 hold: Q.
  - 001 clear: 0.
  - 010 load: I.
  - 011 increment: Q+1, modulo 2^WIDTH; all-ones wraps to 0.
  - 100 decrement: Q-1, modulo 2^WIDTH; 0 wraps to all-ones.
  - 101 load low half, zero-extend: {0, I[15:0]}.
  - 110 load low half, sign-extend: {replicate I[15], I[15:0]}.
  - 111 load low byte only: Q[WIDTH-1:8] kept, I[7:0] written.
- Simultaneous events:
  - Any combination of RegSel/ScrSel bits may be set in one cycle.
  - The same FunSel applies independently to each selected register, each using its own Q.
  - With no enables set, nothing changes regardless of FunSel.
- Latency: one cycle from write inputs to OutA/OutB; zero cycles from select inputs to outputs.
- No X-propagation: every FunSel and select code is defined.

Decomposition:
- Shared package `rf_pkg` holds:
  - FunSel constants: RF_HOLD, RF_CLR, RF_LOAD, RF_INC, RF_DEC, RF_LDZ16, RF_LDS16, RF_LDB0.
  - Read-select constants: SEL_R1..SEL_R4, SEL_S1..SEL_S4.
- One sub-module `rf_reg_cell`:
  - Contents: a WIDTH-bit register with enable, synchronous reset and the FunSel next-state logic.
  - Instantiation: eight times.
- The top level holds only the enable fan-out and the two 8:1 read muxes.

Test Plan:
1. Reset → all registers zero: preload all regs with 0xDEADBEEF, then assert Reset for one edge → OutA/OutB read 0 for every select code.
2. Load visibility:
   - Cycle 1: RegSel=1000, FunSel=010, I=0x12345678, OutASel=000 → OutA still shows old R1 during that cycle.
   - Cycle 2: OutA shows 0x12345678.
3. Increment and decrement wrap:
   - S2=0xFFFFFFFF, FunSel=011 → 0x00000000.
   - Then FunSel=100, twice → 0xFFFFFFFF, then 0xFFFFFFFE.
4. Half and byte loads with I=0xABCD8001:
   - FunSel=110 to R3 → 0xFFFF8001.
   - FunSel=101 to R4 → 0x00008001.
   - R2=0x11223344, FunSel=111 → 0x11223301.
5. Multi-select write: RegSel=1111, ScrSel=1111, FunSel=010, I=0x5A5A5A5A → all eight selects read 0x5A5A5A5A the next cycle.
6. Reset mid-operation: R1=5, FunSel=011 with Reset=1 on the same edge → R1=0, not 6. Increment on the following edge → 1.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared encodings for the operand register file: micro-op and read-select codes.
package rf_pkg;

    // Register micro-operations applied to every selected register
    localparam logic [2:0] RF_HOLD  = 3'b000;
    localparam logic [2:0] RF_CLR   = 3'b001;
    localparam logic [2:0] RF_LOAD  = 3'b010;
    localparam logic [2:0] RF_INC   = 3'b011;
    localparam logic [2:0] RF_DEC   = 3'b100;
    localparam logic [2:0] RF_LDZ16 = 3'b101;
    localparam logic [2:0] RF_LDS16 = 3'b110;
    localparam logic [2:0] RF_LDB0  = 3'b111;

    // Read-select codes shared by the A and B output muxes
    localparam logic [2:0] SEL_R1 = 3'b000;
    localparam logic [2:0] SEL_R2 = 3'b001;
    localparam logic [2:0] SEL_R3 = 3'b010;
    localparam logic [2:0] SEL_R4 = 3'b011;
    localparam logic [2:0] SEL_S1 = 3'b100;
    localparam logic [2:0] SEL_S2 = 3'b101;
    localparam logic [2:0] SEL_S3 = 3'b110;
    localparam logic [2:0] SEL_S4 = 3'b111;

endpackage

// File: rtl/rf_reg_cell.sv
// One register of the file: enable, synchronous reset and micro-op next-state logic.
module rf_reg_cell
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             en,
    input  logic [2:0]       fun_sel,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next value from the selected micro-op; hold when not enabled
    always_comb begin
        q_d = q_q;
        if (en) begin
            case (fun_sel)
                RF_HOLD:  q_d = q_q;
                RF_CLR:   q_d = '0;
                RF_LOAD:  q_d = data;
                RF_INC:   q_d = q_q + WIDTH'(1);
                RF_DEC:   q_d = q_q - WIDTH'(1);
                RF_LDZ16: q_d = {{(WIDTH-16){1'b0}}, data[15:0]};
                RF_LDS16: q_d = {{(WIDTH-16){data[15]}}, data[15:0]};
                RF_LDB0:  q_d = {q_q[WIDTH-1:8], data[7:0]};
                default:  q_d = q_q;
            endcase
        end
    end

    // State register; reset wins over any write in the same cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/register_file.sv
// Operand register bank (R1-R4, S1-S4) feeding the ALU A/B buses.
module register_file
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic [3:0]       RegSel,
    input  logic [3:0]       ScrSel,
    input  logic [2:0]       OutASel,
    input  logic [2:0]       OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB
);

    // Cell index k matches the read-select code: 0-3 = R1-R4, 4-7 = S1-S4
    logic [7:0]       en;
    logic [WIDTH-1:0] regs [8];

    // Enable fan-out; select bit 3 addresses the lowest-numbered register
    always_comb begin
        en = '0;
        for (int k = 0; k < 4; k++) begin
            en[k]     = RegSel[3-k];
            en[k + 4] = ScrSel[3-k];
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_cell
        rf_reg_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .Clock  (Clock),
            .Reset  (Reset),
            .en     (en[k]),
            .fun_sel(FunSel),
            .data   (I),
            .q      (regs[k])
        );
    end

    // A read mux: purely combinational, no write bypass
    always_comb begin
        OutA = '0;
        case (OutASel)
            SEL_R1:  OutA = regs[0];
            SEL_R2:  OutA = regs[1];
            SEL_R3:  OutA = regs[2];
            SEL_R4:  OutA = regs[3];
            SEL_S1:  OutA = regs[4];
            SEL_S2:  OutA = regs[5];
            SEL_S3:  OutA = regs[6];
            SEL_S4:  OutA = regs[7];
            default: OutA = '0;
        endcase
    end

    // B read mux: same encoding as A, fully independent
    always_comb begin
        OutB = '0;
        case (OutBSel)
            SEL_R1:  OutB = regs[0];
            SEL_R2:  OutB = regs[1];
            SEL_R3:  OutB = regs[2];
            SEL_R4:  OutB = regs[3];
            SEL_S1:  OutB = regs[4];
            SEL_S2:  OutB = regs[5];
            SEL_S3:  OutB = regs[6];
            SEL_S4:  OutB = regs[7];
            default: OutB = '0;
        endcase
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with hand-computed expectations.
module tb_register_file;
    import rf_pkg::*;

    logic        Clock;
    logic        Reset;
    logic [31:0] I;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [31:0] OutA;
    logic [31:0] OutB;

    int n_cmp = 0;
    int n_err = 0;

    register_file #(
        .WIDTH(32)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .I      (I),
        .FunSel (FunSel),
        .RegSel (RegSel),
        .ScrSel (ScrSel),
        .OutASel(OutASel),
        .OutBSel(OutBSel),
        .OutA   (OutA),
        .OutB   (OutB)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge, leaving inputs safe to change
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One-cycle write, enables dropped afterwards
    task automatic wr(input logic [3:0] rs, input logic [3:0] ss, input logic [2:0] fs,
                      input logic [31:0] d);
        RegSel = rs;
        ScrSel = ss;
        FunSel = fs;
        I      = d;
        tick();
        RegSel = '0;
        ScrSel = '0;
        FunSel = RF_HOLD;
    endtask

    task automatic rd(input string tag, input logic [2:0] sa, input logic [2:0] sb,
                      input logic [31:0] ea, input logic [31:0] eb);
        OutASel = sa;
        OutBSel = sb;
        #1;
        check_eq({tag, ".A"}, OutA, ea);
        check_eq({tag, ".B"}, OutB, eb);
    endtask

    initial begin
        Reset   = 1'b1;
        I       = '0;
        FunSel  = RF_HOLD;
        RegSel  = '0;
        ScrSel  = '0;
        OutASel = SEL_R1;
        OutBSel = SEL_R1;
        #2;
        tick();
        Reset = 1'b0;

        // 1: preload everything, then reset clears all eight
        wr(4'hF, 4'hF, RF_LOAD, 32'hDEADBEEF);
        rd("preload", SEL_R3, SEL_S4, 32'hDEADBEEF, 32'hDEADBEEF);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int s = 0; s < 8; s++) begin
            rd($sformatf("reset_sel%0d", s), 3'(s), 3'(7 - s), 32'h0, 32'h0);
        end

        // 2: load not visible until after the edge
        wr(4'b1000, 4'b0000, RF_LOAD, 32'h11111111);
        RegSel  = 4'b1000;
        FunSel  = RF_LOAD;
        I       = 32'h12345678;
        OutASel = SEL_R1;
        OutBSel = SEL_R2;
        #1;
        check_eq("load_before_edge", OutA, 32'h11111111);
        tick();
        RegSel = '0;
        FunSel = RF_HOLD;
        rd("load_after_edge", SEL_R1, SEL_R1, 32'h12345678, 32'h12345678);

        // 3: increment/decrement wrap on S2
        wr(4'b0000, 4'b0100, RF_LOAD, 32'hFFFFFFFF);
        wr(4'b0000, 4'b0100, RF_INC, 32'h0);
        rd("inc_wrap", SEL_S2, SEL_R1, 32'h00000000, 32'h12345678);
        wr(4'b0000, 4'b0100, RF_DEC, 32'h0);
        rd("dec_wrap", SEL_S2, SEL_S1, 32'hFFFFFFFF, 32'h0);
        wr(4'b0000, 4'b0100, RF_DEC, 32'h0);
        rd("dec_again", SEL_S2, SEL_S3, 32'hFFFFFFFE, 32'h0);

        // 4: half and byte loads
        wr(4'b0001, 4'b0000, RF_LOAD, 32'hFFFFFFFF);
        wr(4'b0010, 4'b0000, RF_LDS16, 32'hABCD8001);
        rd("lds16", SEL_R3, SEL_R4, 32'hFFFF8001, 32'hFFFFFFFF);
        wr(4'b0001, 4'b0000, RF_LDZ16, 32'hABCD8001);
        rd("ldz16", SEL_R4, SEL_R3, 32'h00008001, 32'hFFFF8001);
        wr(4'b0010, 4'b0000, RF_LDS16, 32'h12347FFF);
        rd("lds16_pos", SEL_R3, SEL_R1, 32'h00007FFF, 32'h12345678);
        wr(4'b0100, 4'b0000, RF_LOAD, 32'h11223344);
        wr(4'b0100, 4'b0000, RF_LDB0, 32'hABCD8001);
        rd("ldb0", SEL_R2, SEL_R2, 32'h11223301, 32'h11223301);

        // 5: all eight at once, then no-enable clear changes nothing
        wr(4'hF, 4'hF, RF_LOAD, 32'h5A5A5A5A);
        for (int s = 0; s < 8; s++) begin
            rd($sformatf("multi_sel%0d", s), 3'(s), 3'(s), 32'h5A5A5A5A, 32'h5A5A5A5A);
        end
        wr(4'b0000, 4'b0000, RF_CLR, 32'h0);
        rd("no_enable", SEL_R1, SEL_S4, 32'h5A5A5A5A, 32'h5A5A5A5A);
        wr(4'b0000, 4'b1000, RF_CLR, 32'h0);
        rd("clr_s1", SEL_S1, SEL_S2, 32'h0, 32'h5A5A5A5A);

        // 6: reset overrides a same-edge increment
        wr(4'b1000, 4'b0000, RF_LOAD, 32'h5);
        rd("pre_reset_r1", SEL_R1, SEL_R2, 32'h5, 32'h5A5A5A5A);
        RegSel = 4'b1000;
        FunSel = RF_INC;
        Reset  = 1'b1;
        tick();
        Reset = 1'b0;
        RegSel = '0;
        FunSel = RF_HOLD;
        rd("reset_mid", SEL_R1, SEL_S3, 32'h0, 32'h0);
        wr(4'b1000, 4'b0000, RF_INC, 32'h0);
        rd("inc_after_reset", SEL_R1, SEL_R2, 32'h1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
